// File: rtl/coin_panel_conditioner.sv
// coin_panel_conditioner
// Front-panel input stage for the vending controller. Five raw push-buttons are
// synchronised and debounced. Each debounced press becomes a single-cycle command,
// and simultaneous presses are serialised so that at most one command goes out per clock.
// Channel index: 0 coin1, 1 coin10, 2 drink1, 3 drink2, 4 cancel.

module coin_panel_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_coin1,
  input  logic       btn_coin10,
  input  logic       btn_drink1,
  input  logic       btn_drink2,
  input  logic       btn_cancel,
  output logic       insert,
  output logic [1:0] coin_val,
  output logic [1:0] drink_op,
  output logic       cancel_flag,
  output logic       drop_pulse
);

  localparam int CH_COIN1  = 0;
  localparam int CH_COIN10 = 1;
  localparam int CH_DRINK1 = 2;
  localparam int CH_DRINK2 = 3;
  localparam int CH_CANCEL = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       w_raw;
  logic [4:0]       r_meta;
  logic [4:0]       r_sync;
  logic [4:0]       r_stable;
  logic [4:0]       r_stable_d;
  logic [CNT_W-1:0] r_cnt [5];
  logic [4:0]       r_pending;
  logic [4:0]       w_rise;
  logic [4:0]       w_grant;

  assign w_raw = {btn_cancel, btn_drink2, btn_drink1, btn_coin10, btn_coin1};

  // Two-flop synchroniser for every button.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

  // Per-channel debounce: the stable level follows sync only after it has differed
  // for DEBOUNCE_CYCLES consecutive cycles. Press and release use the same rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= '0;
      for (int ch = 0; ch < 5; ch++) r_cnt[ch] <= '0;
    end else begin
      for (int ch = 0; ch < 5; ch++) begin
        if (r_sync[ch] == r_stable[ch]) begin
          r_cnt[ch] <= '0;
        end else if (r_cnt[ch] == CNT_MAX) begin
          r_stable[ch] <= r_sync[ch];
          r_cnt[ch]    <= '0;
        end else begin
          r_cnt[ch] <= r_cnt[ch] + CNT_W'(1);
        end
      end
    end
  end

  // Delayed copy of the stable level, used for 0->1 press detection.
  always_ff @(posedge clk) begin
    if (rst) r_stable_d <= '0;
    else     r_stable_d <= r_stable;
  end

  assign w_rise = r_stable & ~r_stable_d;

  // Fixed-priority pick of one pending command: cancel > coin10 > coin1 > drink2 > drink1.
  always_comb begin
    w_grant = '0;
    if      (r_pending[CH_CANCEL]) w_grant[CH_CANCEL] = 1'b1;
    else if (r_pending[CH_COIN10]) w_grant[CH_COIN10] = 1'b1;
    else if (r_pending[CH_COIN1])  w_grant[CH_COIN1]  = 1'b1;
    else if (r_pending[CH_DRINK2]) w_grant[CH_DRINK2] = 1'b1;
    else if (r_pending[CH_DRINK1]) w_grant[CH_DRINK1] = 1'b1;
  end

  // Pending bookkeeping and registered command outputs. A new press on a channel
  // that is still pending stays merged into that one command and is flagged as dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= '0;
      insert      <= 1'b0;
      coin_val    <= 2'b00;
      drink_op    <= 2'b00;
      cancel_flag <= 1'b0;
      drop_pulse  <= 1'b0;
    end else begin
      r_pending   <= (r_pending & ~w_grant) | w_rise;
      insert      <= w_grant[CH_COIN1] | w_grant[CH_COIN10];
      coin_val    <= {w_grant[CH_COIN10], w_grant[CH_COIN1]};
      drink_op    <= {w_grant[CH_DRINK2], w_grant[CH_DRINK1]};
      cancel_flag <= w_grant[CH_CANCEL];
      drop_pulse  <= |(w_rise & r_pending);
    end
  end

endmodule

// File: tb/tb_coin_panel_conditioner.sv
// Directed bench for coin_panel_conditioner with DEBOUNCE_CYCLES = 4.
// Outputs are packed as {insert, coin_val, drink_op, cancel_flag, drop_pulse}.

module tb_coin_panel_conditioner;

  logic       clk;
  logic       rst;
  logic       btn_coin1, btn_coin10, btn_drink1, btn_drink2, btn_cancel;
  logic       insert;
  logic [1:0] coin_val;
  logic [1:0] drink_op;
  logic       cancel_flag;
  logic       drop_pulse;
  logic [6:0] obs;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [6:0] NONE   = 7'b0_00_00_0_0;
  localparam logic [6:0] COIN1  = 7'b1_01_00_0_0;
  localparam logic [6:0] COIN10 = 7'b1_10_00_0_0;
  localparam logic [6:0] DRINK1 = 7'b0_00_01_0_0;
  localparam logic [6:0] DRINK2 = 7'b0_00_10_0_0;
  localparam logic [6:0] CANCEL = 7'b0_00_00_1_0;
  localparam logic [6:0] CANDRP = 7'b0_00_00_1_1;

  coin_panel_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_coin1  (btn_coin1),
    .btn_coin10 (btn_coin10),
    .btn_drink1 (btn_drink1),
    .btn_drink2 (btn_drink2),
    .btn_cancel (btn_cancel),
    .insert     (insert),
    .coin_val   (coin_val),
    .drink_op   (drink_op),
    .cancel_flag(cancel_flag),
    .drop_pulse (drop_pulse)
  );

  assign obs = {insert, coin_val, drink_op, cancel_flag, drop_pulse};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // At most one command class may be active in any cycle.
  always @(negedge clk) begin
    int active;
    active = int'(insert) + int'(|drink_op) + int'(cancel_flag);
    n_assert++;
    assert (active <= 1) else begin
      n_fail++;
      $error("FAIL onehot observed %0d active commands required <=1", active);
    end
  end

  // Advance ncyc clocks, checking outputs 1 ns after each edge. Cycle i (1-based)
  // must show v1/v2/v3 when i equals at1/at2/at3, otherwise all-zero.
  task automatic watch(input int ncyc, input int at1, input logic [6:0] v1,
                       input int at2, input logic [6:0] v2,
                       input int at3, input logic [6:0] v3, input string tag);
    logic [6:0] exp_v;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk);
      #1;
      exp_v = NONE;
      if (i == at1) exp_v = v1;
      if (i == at2) exp_v = v2;
      if (i == at3) exp_v = v3;
      n_assert++;
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s cycle %0d observed %b required %b", tag, i, obs, exp_v);
      end
    end
  endtask

  task automatic watch1(input int ncyc, input int at, input logic [6:0] v, input string tag);
    watch(ncyc, at, v, 0, NONE, 0, NONE, tag);
  endtask

  task automatic quiet(input int ncyc, input string tag);
    watch(ncyc, 0, NONE, 0, NONE, 0, NONE, tag);
  endtask

  initial begin
    rst = 1'b1;
    btn_coin1 = 1'b0; btn_coin10 = 1'b0; btn_drink1 = 1'b0;
    btn_drink2 = 1'b0; btn_cancel = 1'b0;
    quiet(2, "reset_state");
    rst = 1'b0;
    quiet(3, "idle");

    // 1: clean coin1 press held 20 cycles, then release
    btn_coin1 = 1'b1;
    watch1(20, 8, COIN1, "s1_press");
    btn_coin1 = 1'b0;
    quiet(12, "s1_release");

    // 2: coin10 bouncing every 2 cycles, then stable high
    btn_coin10 = 1'b1; quiet(2, "s2_b1");
    btn_coin10 = 1'b0; quiet(2, "s2_b2");
    btn_coin10 = 1'b1; quiet(2, "s2_b3");
    btn_coin10 = 1'b0; quiet(2, "s2_b4");
    btn_coin10 = 1'b1;
    watch1(14, 8, COIN10, "s2_stable");
    btn_coin10 = 1'b0;
    quiet(12, "s2_release");

    // 3: cancel, coin10 and drink1 together, serialised by priority
    btn_cancel = 1'b1; btn_coin10 = 1'b1; btn_drink1 = 1'b1;
    watch(14, 8, CANCEL, 9, COIN10, 10, DRINK1, "s3_simul");
    btn_cancel = 1'b0; btn_coin10 = 1'b0; btn_drink1 = 1'b0;
    quiet(12, "s3_release");

    // 4: drink2 glitch of 3 synced cycles ignored, 4 synced cycles accepted
    btn_drink2 = 1'b1; quiet(3, "s4_glitch3_hi");
    btn_drink2 = 1'b0; quiet(12, "s4_glitch3_lo");
    btn_drink2 = 1'b1; quiet(4, "s4_glitch4_hi");
    btn_drink2 = 1'b0;
    watch1(12, 4, DRINK2, "s4_glitch4_lo");

    // 5: reset while coin1 and drink1 are pending discards both
    btn_coin1 = 1'b1; btn_drink1 = 1'b1;
    quiet(7, "s5_debounce");
    btn_coin1 = 1'b0; btn_drink1 = 1'b0;
    rst = 1'b1;
    quiet(1, "s5_after_reset");
    rst = 1'b0;
    quiet(15, "s5_discarded");

    // 6a: coin1 held through reset release yields one command
    btn_coin1 = 1'b1;
    rst = 1'b1;
    quiet(2, "s6_reset");
    rst = 1'b0;
    watch1(12, 8, COIN1, "s6_held");

    // 6b: second press on coin1 while its command waits behind cancel
    btn_cancel = 1'b1;
    rst = 1'b1;
    quiet(2, "s6b_reset");
    rst = 1'b0;
    quiet(7, "s6b_debounce");
    force dut.w_rise = 5'b00001;
    watch1(1, 1, CANDRP, "s6b_cancel_drop");
    release dut.w_rise;
    watch1(12, 1, COIN1, "s6b_single_coin1");
    btn_coin1 = 1'b0; btn_cancel = 1'b0;
    quiet(12, "s6b_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
